// File: rtl/aes_pkg.sv
// Shared AES datapath types: byte/state typedefs, buffer occupancy enum.
// Optional macro SHIFT_ROWS_FWD_EN adds a forward ShiftRows select in users.
package aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef logic [7:0] aes_byte_t;

    // Index 0 is the most significant byte (b0 = [127:120]).
    typedef aes_byte_t [0:15] aes_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } occ_e;

endpackage

// File: rtl/state_row_rotate.sv
// Combinational AES row rotation (InvShiftRows, or ShiftRows via dir).
// dir exists only when SHIFT_ROWS_FWD_EN is defined.
module state_row_rotate
    import aes_pkg::*;
(
`ifdef SHIFT_ROWS_FWD_EN
    input  logic                   dir,
`endif
    input  logic [AES_STATE_W-1:0] state,
    output logic [AES_STATE_W-1:0] shifted
);

    aes_state_t src;
    aes_state_t dst;

    assign src     = state;
    assign shifted = dst;

    // Byte 4c+r is row r, column c of the column-major state.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int INV = 4 * ((c + 4 - r) % 4) + r;
`ifdef SHIFT_ROWS_FWD_EN
            localparam int FWD = 4 * ((c + r) % 4) + r;
            assign dst[4*c+r] = dir ? src[FWD] : src[INV];
`else
            assign dst[4*c+r] = src[INV];
`endif
        end
    end

endmodule

// File: rtl/inv_shift_rows_stage.sv
// InvShiftRows pipeline stage with a 2-entry output buffer.
// SHIFT_ROWS_FWD_EN adds in_fwd to select forward ShiftRows per state.
module inv_shift_rows_stage
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
`ifdef SHIFT_ROWS_FWD_EN
    input  logic                   in_fwd,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
);

    occ_e                   state_q;
    occ_e                   state_d;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [AES_STATE_W-1:0] entry [2];
    logic [AES_STATE_W-1:0] shifted;
    logic                   push;
    logic                   pop;

    state_row_rotate u_rotate (
`ifdef SHIFT_ROWS_FWD_EN
        .dir     (in_fwd),
`endif
        .state   (in_data),
        .shifted (shifted)
    );

    // Handshake outputs come from registered occupancy only.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = entry[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop) state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL: if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                entry[wr_ptr] <= shifted;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: doc/inv_shift_rows_stage.md
# inv_shift_rows_stage

Handshaked pipeline stage applying the AES-128 InvShiftRows transformation to a 128-bit state, with a 2-entry output buffer so upstream and downstream can stall independently. It sits in the decryption datapath between the round-key/InvMixColumns logic and InvSubBytes. It is the decryption-side counterpart of the forward ShiftRows used in encryption.

## Interface
- No parameters; state width is fixed at 128 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous, active-low.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept; equals buffer not full.
- in_data  in  128  input state; byte b0 = [127:120] … b15 = [7:0]; column-major (row r, column c is byte 4c+r).
- out_valid  out  1  out_data holds the oldest buffered result.
- out_ready  in  1  downstream accepts.
- out_data  out  128  transformed state, same byte layout.
- in_fwd  in  1  present only with SHIFT_ROWS_FWD_EN; 1 selects forward ShiftRows.

## Operation
- Inverse mapping: out[r,c] = in[r,(c−r) mod 4].
  - Row 0: unchanged (b0, b4, b8, b12).
  - Row 1: b1←b13, b5←b1, b9←b5, b13←b9.
  - Row 2: b2←b10, b6←b14, b10←b2, b14←b6.
  - Row 3: b3←b7, b7←b11, b11←b15, b15←b3.
- Transform is applied on the way in; the buffer stores transformed states.
- Input accept: in_valid && in_ready. Output pop: out_valid && out_ready.
- Occupancy FSM: EMPTY → ONE on push only. ONE → FULL on push only. ONE → EMPTY on pop only. ONE stays ONE on simultaneous push and pop. FULL → ONE on pop.
- No push is possible in FULL: in_ready=0 there, including in a cycle where a pop occurs.
- 2-entry circular buffer with 1-bit write and read pointers, each wrapping 1→0.
- out_data = entry[rd_ptr]. It holds stable while out_valid && !out_ready.
- Ordering is strict FIFO. No data is dropped or duplicated.

## Timing
- Latency is 1 cycle: a state accepted at edge N is presented with out_valid=1 after edge N.
- Throughput is 1 state/cycle when out_ready is held high.
- in_ready and out_valid are decoded from registered state only. There is no combinational in→out path.
- Reset values: FSM=EMPTY, pointers=0, entries=0, out_valid=0, out_data=0, in_ready=1.
- Reset asserted mid-transfer discards all buffered states immediately (asynchronously). The first accept after rst_n deasserts is stored in entry 0.
- out_valid never drops without a pop. in_ready never drops without a push.

## Configuration
- SHIFT_ROWS_FWD_EN defined:
  - in_fwd port exists.
  - Each accepted state uses the forward mapping out[r,c] = in[r,(c+r) mod 4] when in_fwd=1, and the inverse mapping when in_fwd=0.
  - in_fwd is sampled with in_data on accept.
- Not defined:
  - No in_fwd port.
  - Inverse mapping only.

## Structure
- Shared package aes_pkg holds:
  - byte typedef (8 bits) and state typedef (16 bytes);
  - occupancy enum {EMPTY, ONE, FULL};
  - constant AES_STATE_W=128.
- One combinational sub-module, state_row_rotate: 128-bit in, 128-bit out, plus a dir input when SHIFT_ROWS_FWD_EN is defined. It is instantiated once on the input side.

## Test plan
- Single transfer: in_data=0x000102030405060708090a0b0c0d0e0f with out_ready=1 → one cycle later out_valid=1, out_data=0x000d0a0704010e0b0805020f0c090603.
- Inverse check: in_data=0x00050a0f04090e03080d02070c01060b → out_data=0x000102030405060708090a0b0c0d0e0f.
- Back-pressure: out_ready=0 while pushing 3 states → in_ready=0 after the 2nd accept. The 3rd state is held upstream. Then raising out_ready → the 3 outputs appear in order, none lost.
- Streaming: 16 back-to-back states with out_ready=1 → in_ready stays 1 and 16 outputs arrive on 16 consecutive cycles. Pointers wrap correctly.
- Reset mid-operation: buffer FULL, drop rst_n for 1 cycle → out_valid=0 and in_ready=1 immediately. The next output is the first state pushed after reset.
- With SHIFT_ROWS_FWD_EN: in_fwd=1 and in_data=0x000102030405060708090a0b0c0d0e0f → out_data=0x00050a0f04090e03080d02070c01060b.
